// File: rtl/teclado_debounce_decoder.sv
// Debounces keypad scanner sightings across scan rounds and emits one registered
// key event (calculator code) per physical press, plus a release pulse.
module teclado_debounce_decoder #(
   parameter int DEBOUNCE_HITS  = 8,
   parameter int SCAN_WINDOW    = 8,
   parameter int RELEASE_WINDOW = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [5:0] indice_boton,
   input  logic       button_pressed,
   output logic       key_valid,
   output logic [4:0] key_code,
   output logic       key_is_digit,
   output logic       key_release,
   output logic       key_held,
   output logic       scan_error
);

   localparam int HITS_W = $clog2(DEBOUNCE_HITS + 1);
   localparam int GAP_W  = $clog2(RELEASE_WINDOW + 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CONFIRM = 2'd1;
   localparam logic [1:0] ST_HELD    = 2'd2;

   logic [1:0]        state_reg, state_next;
   logic [3:0]        cand_reg, cand_next;
   logic [HITS_W-1:0] hits_reg, hits_next;
   logic [GAP_W-1:0]  gap_reg, gap_next;
   logic [4:0]        code_reg, code_next;
   logic              digit_reg, digit_next;
   logic              valid_reg, valid_next;
   logic              release_reg, release_next;
   logic              scan_err_reg;

   logic              sighting;
   logic              match;
   logic [3:0]        key_now;
   logic [4:0]        cand_code;
   logic [HITS_W-1:0] hits_inc;
   logic [GAP_W-1:0]  gap_inc;

   // Key index is {col[1:0], row[1:0]}.
   function automatic logic [4:0] key_map(input logic [3:0] k);
      logic [4:0] code;
      case (k)
         4'b00_00: code = 5'd1;
         4'b01_00: code = 5'd2;
         4'b10_00: code = 5'd3;
         4'b11_00: code = 5'd10;
         4'b00_01: code = 5'd4;
         4'b01_01: code = 5'd5;
         4'b10_01: code = 5'd6;
         4'b11_01: code = 5'd11;
         4'b00_10: code = 5'd7;
         4'b01_10: code = 5'd8;
         4'b10_10: code = 5'd9;
         4'b11_10: code = 5'd12;
         4'b00_11: code = 5'd14;
         4'b01_11: code = 5'd0;
         4'b10_11: code = 5'd15;
         default:  code = 5'd13;
      endcase
      return code;
   endfunction

   assign sighting  = enable & button_pressed & ~indice_boton[5] & ~indice_boton[2];
   assign key_now   = {indice_boton[4:3], indice_boton[1:0]};
   assign match     = sighting && (key_now == cand_reg);
   assign cand_code = key_map(cand_reg);
   assign hits_inc  = hits_reg + 1'b1;
   // Saturating so a long silence can never wrap back under a limit.
   assign gap_inc   = (gap_reg == {GAP_W{1'b1}}) ? gap_reg : gap_reg + 1'b1;

   always_comb begin
      state_next   = state_reg;
      cand_next    = cand_reg;
      hits_next    = hits_reg;
      gap_next     = gap_reg;
      code_next    = code_reg;
      digit_next   = digit_reg;
      valid_next   = 1'b0;
      release_next = 1'b0;
      if (enable) begin
         case (state_reg)
            ST_IDLE: begin
               if (sighting) begin
                  cand_next  = key_now;
                  hits_next  = HITS_W'(1);
                  gap_next   = '0;
                  state_next = ST_CONFIRM;
               end
            end
            ST_CONFIRM: begin
               if (match) begin
                  hits_next = hits_inc;
                  gap_next  = '0;
                  if (hits_inc == HITS_W'(DEBOUNCE_HITS)) begin
                     code_next  = cand_code;
                     digit_next = (cand_code <= 5'd9);
                     valid_next = 1'b1;
                     state_next = ST_HELD;
                  end
               end else if (sighting) begin
                  cand_next = key_now;
                  hits_next = HITS_W'(1);
                  gap_next  = '0;
               end else begin
                  gap_next = gap_inc;
                  if (gap_inc == GAP_W'(SCAN_WINDOW))
                     state_next = ST_IDLE;
               end
            end
            ST_HELD: begin
               // Other keys are ignored here: first key wins, no rollover.
               if (match) begin
                  gap_next = '0;
               end else begin
                  gap_next = gap_inc;
                  if (gap_inc == GAP_W'(RELEASE_WINDOW)) begin
                     release_next = 1'b1;
                     state_next   = ST_IDLE;
                  end
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         cand_reg     <= '0;
         hits_reg     <= '0;
         gap_reg      <= '0;
         code_reg     <= '0;
         digit_reg    <= 1'b0;
         valid_reg    <= 1'b0;
         release_reg  <= 1'b0;
         scan_err_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cand_reg     <= cand_next;
         hits_reg     <= hits_next;
         gap_reg      <= gap_next;
         code_reg     <= code_next;
         digit_reg    <= digit_next;
         valid_reg    <= valid_next;
         release_reg  <= release_next;
         scan_err_reg <= enable & indice_boton[5];
      end
   end

   assign key_valid    = valid_reg;
   assign key_code     = code_reg;
   assign key_is_digit = digit_reg;
   assign key_release  = release_reg;
   assign key_held     = (state_reg == ST_HELD);
   assign scan_error   = scan_err_reg;

endmodule
